fb_scan_reader: RTL and testbench

- Read-side counterpart of the transformation/write path. It sweeps the 16x16 framebuffer in raster order and issues one read address per active pixel.
- It realigns the returned memory data with fixed-latency sideband markers and emits a pixel stream with line and frame markers for the display/output stage.
- It sits between the framebuffer memory read port and the screen output logic.

---
 rtl/fb_scan_reader.sv | 169 ++++++++++++++++
 tb/tb_fb_scan_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scan_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_scan_reader: raster-order framebuffer read sweep with latency-aligned  |
// | pixel stream and line/frame markers.            Rev 1.0                  |
// +--------------------------------------------------------------------------+
module fb_scan_reader #(
  parameter int H_ACTIVE = 16,
  parameter int V_ACTIVE = 16,
  parameter int H_BLANK  = 4,
  parameter int V_BLANK  = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              ENB,
  input  logic              START,
  input  logic              CONT,
  output logic [ADDR_W-1:0] RdAddr,
  output logic              RdEn,
  input  logic [DATA_W-1:0] RdData,
  output logic [DATA_W-1:0] PixOut,
  output logic              PixValid,
  output logic              LineStart,
  output logic              FrameStart,
  output logic              FrameDone,
  output logic              Busy
);

  localparam int c_h_total = H_ACTIVE + H_BLANK;
  localparam int c_v_total = V_ACTIVE + V_BLANK;
  localparam int c_hw      = (c_h_total > 1) ? $clog2(c_h_total) : 1;
  localparam int c_vw      = (c_v_total > 1) ? $clog2(c_v_total) : 1;
  localparam logic [c_hw-1:0] c_h_max = c_hw'(c_h_total - 1);
  localparam logic [c_vw-1:0] c_v_max = c_vw'(c_v_total - 1);

  // Sideband bit positions: {valid, line_start, frame_start, last_pixel}
  localparam int c_b_valid = 3;
  localparam int c_b_ls    = 2;
  localparam int c_b_fs    = 1;
  localparam int c_b_lp    = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_hw-1:0] r_hcnt;
  logic [c_vw-1:0] r_vcnt;
  logic [3:0]      r_side [0:RD_LAT];

  logic              w_step;
  logic              w_active;
  logic              w_issue;
  logic              w_last_px;
  logic [3:0]        w_side_in;
  logic [3:0]        w_side_out;
  logic [ADDR_W-1:0] w_addr;
  logic              w_pipe_busy;

  assign w_step     = (r_state == S_SCAN) && ENB;
  assign w_active   = (int'(r_hcnt) < H_ACTIVE) && (int'(r_vcnt) < V_ACTIVE);
  assign w_issue    = w_step && w_active;
  assign w_last_px  = (int'(r_hcnt) == H_ACTIVE - 1) && (int'(r_vcnt) == V_ACTIVE - 1);
  assign w_addr     = ADDR_W'(r_vcnt) * ADDR_W'(H_ACTIVE) + ADDR_W'(r_hcnt);
  assign w_side_in  = {w_issue,
                       w_issue && (r_hcnt == '0),
                       w_issue && (r_hcnt == '0) && (r_vcnt == '0),
                       w_issue && w_last_px};
  assign w_side_out = r_side[RD_LAT];

  always_comb begin
    w_pipe_busy = 1'b0;
    for (int k = 0; k <= RD_LAT; k++) begin
      w_pipe_busy = w_pipe_busy | r_side[k][c_b_valid];
    end
  end

  // Stage 0 is loaded together with RdEn; stage RD_LAT lines up with RdData.
  // It shifts every cycle so reads already issued complete even with ENB low.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int k = 0; k <= RD_LAT; k++) begin
        r_side[k] <= '0;
      end
    end else begin
      r_side[0] <= w_side_in;
      for (int k = 1; k <= RD_LAT; k++) begin
        r_side[k] <= r_side[k-1];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= S_IDLE;
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      RdEn       <= 1'b0;
      RdAddr     <= '0;
      Busy       <= 1'b0;
      PixOut     <= '0;
      PixValid   <= 1'b0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
      FrameDone  <= 1'b0;
    end else begin
      RdEn <= w_issue;
      if (w_issue) begin
        RdAddr <= w_addr;
      end

      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state <= S_SCAN;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            Busy    <= 1'b1;
          end
        end
        S_SCAN: begin
          if (ENB) begin
            if (r_hcnt == c_h_max) begin
              r_hcnt <= '0;
              if (r_vcnt == c_v_max) begin
                r_vcnt <= '0;
                if (!CONT) begin
                  r_state <= S_DRAIN;
                end
              end else begin
                r_vcnt <= r_vcnt + 1'b1;
              end
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!w_pipe_busy) begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          Busy    <= 1'b0;
        end
      endcase

      PixValid <= w_side_out[c_b_valid];
      if (w_side_out[c_b_valid]) begin
        PixOut     <= RdData;
        LineStart  <= w_side_out[c_b_ls];
        FrameStart <= w_side_out[c_b_fs];
        FrameDone  <= w_side_out[c_b_lp];
      end else begin
        LineStart  <= 1'b0;
        FrameStart <= 1'b0;
        FrameDone  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_scan_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fb_scan_reader: scoreboard bench for fb_scan_reader.   Rev 1.0        |
// +--------------------------------------------------------------------------+
module tb_fb_scan_reader;

  localparam int H_ACTIVE = 16;
  localparam int V_ACTIVE = 16;
  localparam int H_BLANK  = 4;
  localparam int V_BLANK  = 2;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int RD_LAT   = 1;
  localparam int HT       = H_ACTIVE + H_BLANK;
  localparam int VT       = V_ACTIVE + V_BLANK;
  localparam int NPIX     = H_ACTIVE * V_ACTIVE;
  localparam int LAT      = RD_LAT + 1;

  logic clk = 1'b0;
  logic arst_n, enb, start, cont;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_en;
  logic [DATA_W-1:0] rd_data = '0;
  logic [DATA_W-1:0] pix_out;
  logic pix_valid, line_start, frame_start, frame_done, busy;

  fb_scan_reader #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK), .V_BLANK(V_BLANK),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .ACLK(clk), .ARESETn(arst_n), .ENB(enb), .START(start), .CONT(cont),
    .RdAddr(rd_addr), .RdEn(rd_en), .RdData(rd_data),
    .PixOut(pix_out), .PixValid(pix_valid), .LineStart(line_start),
    .FrameStart(frame_start), .FrameDone(frame_done), .Busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: contents are addr XOR key, one-cycle read latency
  logic [7:0] key = 8'h00;
  always @(posedge clk) if (rd_en) rd_data <= DATA_W'(rd_addr ^ key);

  typedef struct { int c; int a; } rd_t;
  rd_t q[$];
  int  fs_q[$];
  int  rd_cyc [NPIX];
  int  n_tests = 0, n_fail = 0;
  int  pix_cnt = 0, fd_cnt = 0, rd_cnt = 0, exp_next = 0;
  int  frame_p0 = 0, frame_r0 = 0;
  logic [DATA_W-1:0] last_pix = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score everything visible there
  task automatic tick();
    rd_t e;
    @(negedge clk);
    if (!arst_n) begin
      q.delete();
      exp_next = 0;
      last_pix = '0;
      return;
    end
    if (rd_en) begin
      chk("rd_addr", 32'(rd_addr), exp_next);
      q.push_back('{cyc, int'(rd_addr)});
      rd_cyc[int'(rd_addr)] = cyc;
      exp_next = (exp_next + 1) % NPIX;
      rd_cnt++;
    end
    if (pix_valid) begin
      if (q.size() == 0) begin
        chk("pix_unrequested", 1, 0);
      end else begin
        e = q.pop_front();
        chk("pix_latency", cyc - e.c, LAT);
        chk("pix_data", 32'(pix_out), 32'(8'(e.a) ^ key));
        chk("line_start", 32'(line_start), 32'((e.a % H_ACTIVE) == 0));
        chk("frame_start", 32'(frame_start), 32'(e.a == 0));
        chk("frame_done", 32'(frame_done), 32'(e.a == NPIX - 1));
      end
      pix_cnt++;
      if (frame_done) fd_cnt++;
      if (frame_start) fs_q.push_back(cyc);
      last_pix = pix_out;
    end else begin
      chk("idle_markers", 32'({line_start, frame_start, frame_done}), 0);
      chk("pix_hold", 32'(pix_out), 32'(last_pix));
    end
  endtask

  task automatic pulse_start(output int s);
    frame_p0 = pix_cnt;
    frame_r0 = rd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!(pix_valid && frame_done) && n < limit) begin tick(); n++; end
    chk("frame_done_timeout", 32'(n < limit), 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin tick(); n++; end
    chk("busy_timeout", 32'(n < limit), 1);
  endtask

  task automatic wait_read(input int addr, input int limit);
    int n = 0;
    while (!(rd_en && int'(rd_addr) == addr) && n < limit) begin tick(); n++; end
    chk("read_wait_timeout", 32'(n < limit), 1);
  endtask

  // Frame with ENB high except one optional stall after address stall_after
  task automatic full_frame(input int s, input int stall_after, input int stall_len);
    int bad = 0;
    wait_done(4 * HT * VT);
    chk("frame_done_cycle", cyc, s + 1 + (V_ACTIVE-1)*HT + (H_ACTIVE-1) + LAT + stall_len);
    wait_idle(4 * HT * VT);
    chk("busy_fall_cycle", cyc, s + HT*VT + 1 + stall_len);
    for (int a = 0; a < NPIX; a++) begin
      if (rd_cyc[a] != s + 1 + (a / H_ACTIVE)*HT + (a % H_ACTIVE) + ((a > stall_after) ? stall_len : 0))
        bad++;
    end
    chk("rd_schedule", bad, 0);
    chk("pix_count", pix_cnt - frame_p0, NPIX);
    chk("rd_count", rd_cnt - frame_r0, NPIX);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    int s, fs0, fd0, busy_drop, n;
    logic prev_enb;
    arst_n = 1'b0; enb = 1'b1; start = 1'b0; cont = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_pix_out", 32'(pix_out), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_markers", 32'({line_start, frame_start, frame_done}), 0);
    chk("rst_busy", 32'(busy), 0);
    arst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 0);

    // Single frame, data = address
    pulse_start(s);
    chk("busy_after_start", 32'(busy), 1);
    tick();
    chk("first_rd_en", 32'(rd_en), 1);
    full_frame(s, NPIX, 0);

    // Continuous mode for two frames
    key = 8'($urandom);
    cont = 1'b1;
    fs0 = fs_q.size();
    fd0 = fd_cnt;
    busy_drop = 0;
    pulse_start(s);
    n = 0;
    while (fs_q.size() - fs0 < 2 && n < 3 * HT * VT) begin tick(); n++; if (!busy) busy_drop++; end
    chk("cont_fs_timeout", 32'(fs_q.size() - fs0 >= 2), 1);
    cont = 1'b0;
    n = 0;
    while (fd_cnt - fd0 < 2 && n < 3 * HT * VT) begin tick(); n++; if (!busy) busy_drop++; end
    chk("cont_fd_count", fd_cnt - fd0, 2);
    chk("cont_busy_held", busy_drop, 0);
    if (fs_q.size() - fs0 >= 2) chk("cont_fs_period", fs_q[fs0+1] - fs_q[fs0], HT * VT);
    wait_idle(2 * HT * VT);
    chk("cont_busy_fall", cyc, s + 2*HT*VT + 1);
    chk("cont_pix_count", pix_cnt - frame_p0, 2 * NPIX);

    // ENB low for 5 cycles right after address 0x23 is issued
    key = 8'($urandom);
    pulse_start(s);
    wait_read(8'h23, 2 * HT * VT);
    enb = 1'b0;
    repeat (5) begin tick(); chk("stall_rd_en", 32'(rd_en), 0); end
    enb = 1'b1;
    full_frame(s, 8'h23, 5);

    // Spurious START mid-frame
    key = 8'($urandom);
    pulse_start(s);
    repeat ($urandom_range(20, 250)) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    full_frame(s, NPIX, 0);

    // Random ENB pattern
    key = 8'($urandom);
    pulse_start(s);
    n = 0;
    while (!(pix_valid && frame_done) && n < 20 * HT * VT) begin
      prev_enb = enb;
      tick();
      n++;
      if (!prev_enb) chk("enb_low_no_read", 32'(rd_en), 0);
      enb = ($urandom_range(0, 3) != 0);
    end
    enb = 1'b1;
    chk("rand_done_timeout", 32'(n < 20 * HT * VT), 1);
    wait_idle(4 * HT * VT);
    chk("rand_pix_count", pix_cnt - frame_p0, NPIX);
    chk("rand_rd_count", rd_cnt - frame_r0, NPIX);

    // Reset mid-frame at address 0x80
    key = 8'($urandom);
    pulse_start(s);
    wait_read(8'h80, 2 * HT * VT);
    fd0 = fd_cnt;
    #2 arst_n = 1'b0;
    #1;
    chk("arst_rd_addr", 32'(rd_addr), 0);
    chk("arst_rd_en", 32'(rd_en), 0);
    chk("arst_pix_out", 32'(pix_out), 0);
    chk("arst_pix_valid", 32'(pix_valid), 0);
    chk("arst_markers", 32'({line_start, frame_start, frame_done}), 0);
    chk("arst_busy", 32'(busy), 0);
    repeat (3) tick();
    arst_n = 1'b1;
    repeat (4) tick();
    chk("arst_no_frame_done", fd_cnt - fd0, 0);
    chk("arst_idle", 32'({busy, rd_en, pix_valid}), 0);
    key = 8'($urandom);
    pulse_start(s);
    full_frame(s, NPIX, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
